// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ops and an optional shift-add multiplier (enabled by SEQ_ALU_MUL_EN)
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2:0]         Function,
  input  logic               UseReg,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] ALUout,
  output logic               Busy,
  output logic               Done
);
  localparam int W2 = 2 * WIDTH;
  logic [W2-1:0]    alu_q, alu_d, res;
  logic             done_q, done_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum, diff;
  assign b_eff = UseReg ? alu_q[WIDTH-1:0] : B;
  assign sum   = {1'b0, A} + {1'b0, b_eff};
  assign diff  = {1'b0, A} - {1'b0, b_eff};
  // single-cycle result for every function; multiply handled separately
  always_comb begin
    res = '0;
    case (Function)
      3'b000:  res = W2'(sum);
      3'b001:  res = W2'(|{A, b_eff});
      3'b010:  res = W2'(&{A, b_eff});
      3'b011:  res = {A, b_eff};
      3'b100:  res = W2'(diff);
      3'b110:  res = (32'(A) >= W2) ? '0 : W2'(b_eff) << A;
      default: res = '0;
    endcase
  end
`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state_q, state_d;
  logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d, acc_nx;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [4:0]       cnt_q, cnt_d;
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  // accept ops in IDLE; in MUL add one partial product per cycle and publish only the final product
  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE) begin
      if (Start && Function == 3'b101) begin
        state_d  = MUL;
        acc_d    = '0;
        mcand_d  = W2'(A);
        mplier_d = b_eff;
        cnt_d    = '0;
      end else if (Start) begin
        alu_d  = res;
        done_d = 1'b1;
      end
    end else begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'(WIDTH - 1)) begin
        state_d = IDLE;
        alu_d   = acc_nx;
        done_d  = 1'b1;
      end
    end
  end
  // state and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      alu_q    <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
  assign Busy = (state_q == MUL);
`else
  // without the multiplier every op completes on its sampling edge
  always_comb begin
    alu_d  = Start ? res : alu_q;
    done_d = Start;
  end
  // result and done registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_q  <= '0;
      done_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      done_q <= done_d;
    end
  end
  assign Busy = 1'b0;
`endif
  assign ALUout = alu_q;
  assign Done   = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;
  logic           Clock, Reset, Start, UseReg, Busy, Done;
  logic [2:0]     Function;
  logic [W-1:0]   A, B;
  logic [2*W-1:0] ALUout;
  int n_asserts = 0;
  int n_fail = 0;
  int exp_alu = 0;

  seq_alu #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Function(Function), .UseReg(UseReg),
    .A(A), .B(B), .ALUout(ALUout), .Busy(Busy), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int ref_op(input int f, input int a, input int b);
    case (f)
      0: return a + b;
      1: return (a != 0 || b != 0) ? 1 : 0;
      2: return (a == M && b == M) ? 1 : 0;
      3: return a * (M + 1) + b;
      4: return (a - b) & ((2 << W) - 1);
`ifdef SEQ_ALU_MUL_EN
      5: return a * b;
`endif
      6: return (a >= 2 * W) ? 0 : (b << a) & ((1 << (2 * W)) - 1);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input int f, input bit ur, input int a, input int b);
    int be, e;
    @(negedge Clock);
    Start = 1'b1; Function = 3'(f); UseReg = ur; A = W'(a); B = W'(b);
    be = ur ? (exp_alu & M) : b;
    e = ref_op(f, a, be);
    @(posedge Clock); #1;
`ifdef SEQ_ALU_MUL_EN
    if (f == 5) begin
      for (int k = 1; k <= W; k++) begin
        chk("mul_busy", Busy, 1);
        chk("mul_hold", ALUout, exp_alu);
        chk("mul_nodone", Done, 0);
        @(negedge Clock);
        Start = 1'($urandom); Function = 3'($urandom); UseReg = 1'($urandom);
        A = W'($urandom); B = W'($urandom);
        @(posedge Clock); #1;
      end
    end
`endif
    exp_alu = e;
    chk("result", ALUout, e);
    chk("done", Done, 1);
    chk("busy_low", Busy, 0);
  endtask

  task automatic idle();
    @(negedge Clock);
    Start = 1'b0; Function = 3'($urandom); A = W'($urandom); B = W'($urandom);
    @(posedge Clock); #1;
    chk("idle_hold", ALUout, exp_alu);
    chk("idle_nodone", Done, 0);
    chk("idle_busy", Busy, 0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b1; Function = 3'b000; UseReg = 1'b0; A = '1; B = '1;
    @(posedge Clock); #1;
    exp_alu = 0;
    chk("rst_alu", ALUout, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Function = '0; UseReg = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("init_alu", ALUout, 0);
    chk("init_busy", Busy, 0);
    chk("init_done", Done, 0);
    @(negedge Clock);
    Reset = 1'b0;
    do_op(0, 0, 15, 1);
    idle();
    do_op(4, 0, 3, 5);
    do_op(4, 0, 5, 3);
    do_op(0, 0, 1, 2);
    do_op(0, 1, 2, 9);
    do_op(0, 1, 2, 12);
    idle();
    do_op(5, 0, 15, 15);
    idle();
    do_op(5, 0, 3, 3);
    do_op(1, 0, 0, 0);
    do_op(1, 0, 0, 1);
    do_op(2, 0, 15, 15);
    do_op(2, 0, 15, 14);
    do_op(3, 0, 10, 5);
    do_op(6, 0, 3, 9);
    do_op(6, 0, 8, 9);
    do_op(6, 0, 7, 15);
    do_op(7, 0, 9, 9);
    do_op(0, 0, 6, 7);
    do_op(5, 1, 13, 0);
`ifdef SEQ_ALU_MUL_EN
    @(negedge Clock);
    Start = 1'b1; Function = 3'b101; UseReg = 1'b0; A = 4'd7; B = 4'd6;
    @(posedge Clock); #1;
    chk("abort_busy0", Busy, 1);
    @(negedge Clock);
    Start = 1'b0;
    @(posedge Clock); #1;
    chk("abort_busy1", Busy, 1);
`endif
    do_reset();
    repeat (W + 1) idle();
    do_op(0, 0, 9, 8);
    for (int i = 0; i < 80; i++) begin
      do_op($urandom_range(0, 7), 1'($urandom), $urandom_range(0, M), $urandom_range(0, M));
      if ($urandom_range(0, 3) == 0) idle();
    end
    do_reset();
    idle();
    do_op(4, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width in bits; legal range 2..16.
REQ-002 SHALL have port: Clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: Start  input  1  request to execute one operation; sampled only when Busy=0.
REQ-005 SHALL have port: Function  input  3  operation select, encodings per REQ-012.
REQ-006 SHALL have port: UseReg  input  1  1 = B operand taken from ALUout[WIDTH-1:0] instead of B.
REQ-007 SHALL have port: A  input  WIDTH  first operand, unsigned.
REQ-008 SHALL have port: B  input  WIDTH  second operand, unsigned.
REQ-009 SHALL have port: ALUout  output  2*WIDTH  registered result; holds value until the next completed operation.
REQ-010 SHALL have port: Busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 SHALL have port: Done  output  1  one-cycle pulse in the cycle after ALUout updates.

Function
REQ-012 SHALL implement Function: 000 A+B as {0s, carry, sum}; 001 {0s, |{A,B}}; 010 {0s, &{A,B}}; 011 {A,B}; 100 A-B as {0s, borrow, diff}, borrow=1 iff A<B; 101 A*B unsigned; 110 zero-extended B shifted left by A, result 0 if A>=2*WIDTH; 111 clear, ALUout=0.
REQ-013 SHALL capture A, effective B and Function on the edge that samples Start=1 with Busy=0; later input changes SHALL NOT affect that operation.
REQ-014 SHALL, with UseReg=1, use ALUout[WIDTH-1:0] as held before the sampling edge as operand B.
REQ-015 SHALL use FSM states IDLE and MUL: IDLE->MUL on accepted Start with Function=101; MUL->IDLE after WIDTH cycles; all other accepted ops stay in IDLE.
REQ-016 SHALL, for non-multiply ops, update ALUout on the same edge that samples Start; Done=1 for the following cycle.
REQ-017 SHALL, for multiply, use iterative shift-add, one partial product per cycle; Busy=1 from the sampling edge; ALUout updates and Busy falls on edge WIDTH after sampling; Done=1 for the following cycle.
REQ-018 SHALL NOT update ALUout during MUL; intermediate products stay internal.
REQ-019 SHALL ignore Start while Busy=1; no queuing.
REQ-020 SHALL accept a new Start in the cycle Done=1 when Busy=0; back-to-back single-cycle ops give Done high every cycle.
REQ-021 SHALL zero-extend all results to 2*WIDTH bits; carry and borrow occupy bit WIDTH.
REQ-022 SHALL keep ALUout unchanged when Start=0.

Reset
REQ-023 SHALL, on a rising edge with Reset=1, set ALUout=0, Busy=0, Done=0 and FSM=IDLE.
REQ-024 SHALL give Reset priority over Start, including in the same cycle.
REQ-025 SHALL abort an in-progress multiply on Reset; no Done pulse for the aborted op.

Configuration
REQ-026 SHALL, with macro SEQ_ALU_MUL_EN defined, include the MUL state and multiplier datapath per REQ-017.
REQ-027 SHALL, without SEQ_ALU_MUL_EN, treat Function=101 as single-cycle with ALUout=0 and Done pulse; Busy SHALL stay 0 and no multiplier logic SHALL be present.

Verification (WIDTH=4)
REQ-028 SHALL cover: Start, Function=000, A=F, B=1 -> ALUout=8'h10 after that edge, Done=1 next cycle.
REQ-029 SHALL cover: Function=100, A=3, B=5 -> ALUout=8'h1E; A=5, B=3 -> 8'h02.
REQ-030 SHALL cover: MUL_EN defined, Function=101, A=F, B=F -> Busy high 4 cycles, then ALUout=8'hE1, Done pulse; second Start during Busy ignored.
REQ-031 SHALL cover: ALUout=8'h03, UseReg=1, Function=000, A=2 -> ALUout=8'h05; repeat -> 8'h07.
REQ-032 SHALL cover: Reset asserted 2 cycles into a multiply -> ALUout=0, Busy=0, no Done; next Start executes normally.
REQ-033 SHALL cover: MUL_EN undefined, Function=101, A=3, B=3 -> ALUout=0, Busy stays 0, Done pulse.
